// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Purpose : bundles the request/control signals exchanged between the core
//           datapath and the pipeline sequencing controller (pipe_ctrl).
// Signals :
//   stallreq_id  datapath -> ctrl  ID load-use hazard request (level)
//   mc_start     datapath -> ctrl  EX starts a multi-cycle op this cycle
//   mc_len       datapath -> ctrl  total EX cycles of that op (CNT_W bits)
//   flush_req    datapath -> ctrl  redirect/flush request (level)
//   flush_pc_i   datapath -> ctrl  redirect target, valid with flush_req
//   stall        ctrl -> datapath  per-stage hold [0]pc..[5]wb
//   flush        ctrl -> datapath  clear all pipeline registers
//   new_pc       ctrl -> datapath  redirect target (0 when no flush)
//   mc_busy      ctrl -> datapath  multi-cycle op in progress
//   mc_done      ctrl -> datapath  one-cycle pulse, EX result valid
//   stall_cnt    ctrl -> datapath  stall-cycle statistic
// Modports: master = datapath side, slave = pipe_ctrl side.
// -----------------------------------------------------------------------------
interface pipe_ctrl_if #(
  parameter int CNT_W  = 6,
  parameter int ADDR_W = 32
);
  logic              stallreq_id;
  logic              mc_start;
  logic [CNT_W-1:0]  mc_len;
  logic              flush_req;
  logic [ADDR_W-1:0] flush_pc_i;
  logic [5:0]        stall;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic              mc_busy;
  logic              mc_done;
  logic [31:0]       stall_cnt;

  modport master (
    output stallreq_id, mc_start, mc_len, flush_req, flush_pc_i,
    input  stall, flush, new_pc, mc_busy, mc_done, stall_cnt
  );

  modport slave (
    input  stallreq_id, mc_start, mc_len, flush_req, flush_pc_i,
    output stall, flush, new_pc, mc_busy, mc_done, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Purpose : pipeline sequencing controller for the 5-stage core. Merges ID
//           load-use stalls, EX multi-cycle operations and flush requests into
//           one per-stage stall vector, a flush strobe and a redirect PC, and
//           owns the EX multi-cycle countdown FSM.
// Ports   :
//   clk   in  core clock, rising edge
//   rst   in  asynchronous reset, active-low
//   bus   pipe_ctrl_if.slave (requests in, stall/flush/new_pc/mc_busy/
//         mc_done/stall_cnt out)
// Priority: flush_req > EX multi-cycle > stallreq_id.
// Outputs are combinational from state, counter and inputs, and are forced to
// zero while rst is low.
// Optional feature: define PIPE_CTRL_STATS_EN to build the saturating
// stall-cycle counter; otherwise stall_cnt is tied to zero.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int CNT_W  = 6,
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    MC_RUN = 1'b1
  } state_t;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2'd2);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;

  logic [5:0]        stall_s;
  logic              flush_s;
  logic [ADDR_W-1:0] new_pc_s;
  logic              mc_busy_s;
  logic              mc_done_s;
  logic [5:0]        stall_out_s;

  // State and countdown register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and raw (pre-reset-gating) output decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    stall_s     = STALL_NONE;
    flush_s     = 1'b0;
    new_pc_s    = {ADDR_W{1'b0}};
    mc_busy_s   = 1'b0;
    mc_done_s   = 1'b0;

    case (state_r)
      IDLE: begin
        if (bus.flush_req) begin
          flush_s   = 1'b1;
          new_pc_s  = bus.flush_pc_i;
          cnt_nxt_s = CNT_ZERO;
        end else if (bus.mc_start) begin
          mc_busy_s = 1'b1;
          if (bus.mc_len >= CNT_TWO) begin
            // Start cycle is the first of N-1 stalled cycles.
            stall_s     = STALL_EX;
            cnt_nxt_s   = bus.mc_len - CNT_ONE;
            state_nxt_s = MC_RUN;
          end else begin
            // Length 0/1 completes in the start cycle itself.
            mc_done_s = 1'b1;
            stall_s   = bus.stallreq_id ? STALL_ID : STALL_NONE;
          end
        end else if (bus.stallreq_id) begin
          stall_s = STALL_ID;
        end else begin
          stall_s = STALL_NONE;
        end
      end

      MC_RUN: begin
        if (bus.flush_req) begin
          // Abort the op: no completion pulse, counter cleared.
          flush_s     = 1'b1;
          new_pc_s    = bus.flush_pc_i;
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = IDLE;
        end else if (cnt_r > CNT_ONE) begin
          stall_s   = STALL_EX;
          mc_busy_s = 1'b1;
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else if (cnt_r == CNT_ONE) begin
          mc_done_s   = 1'b1;
          mc_busy_s   = 1'b1;
          stall_s     = bus.stallreq_id ? STALL_ID : STALL_NONE;
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = IDLE;
        end else begin
          // cnt==0 cannot occur in MC_RUN; recover to IDLE quietly.
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = IDLE;
        end
      end

      default: begin
        cnt_nxt_s   = CNT_ZERO;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // While reset is held every output is forced low regardless of inputs.
  assign stall_out_s = rst ? stall_s : STALL_NONE;
  assign bus.stall   = stall_out_s;
  assign bus.flush   = rst ? flush_s : 1'b0;
  assign bus.new_pc  = rst ? new_pc_s : {ADDR_W{1'b0}};
  assign bus.mc_busy = rst ? mc_busy_s : 1'b0;
  assign bus.mc_done = rst ? mc_done_s : 1'b0;

`ifdef PIPE_CTRL_STATS_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles with any stage held; flush does not clear it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= 32'h0000_0000;
    end else if ((stall_out_s != STALL_NONE) && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
`else
  assign bus.stall_cnt = 32'h0000_0000;
`endif

endmodule
